// File: rtl/suma_serie_nbits.sv
`default_nettype none
// ============================================================================
//  Module      : suma_1bit
//  Description : 1-bit full-adder cell, {Co,S} = A + B + Ci.
//  Ports       : A, B, Ci - operand bits and carry-in
//                S, Co    - sum bit and carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module suma_1bit (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);
    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));
endmodule

// ============================================================================
//  Module      : suma_serie_nbits
//  Description : Bit-serial N-bit adder. One suma_1bit cell is reused once
//                per clock, LSB first, with the carry recirculated through
//                a flip-flop. start/busy/done handshake; done is a one-cycle
//                pulse N cycles after the accepted start.
//  Parameters  : N - operand/result width (N >= 1)
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - request pulse, sampled only while idle
//                A, B, Ci   - operands and carry-in, latched on start
//                busy, done - handshake status
//                S, Co      - sum and final carry, held until next start
//                V          - signed overflow (only with SUMA_SERIE_OVF_EN)
//  Options     : `define SUMA_SERIE_OVF_EN adds the V output.
//  Revision    : 1.0 - initial release
// ============================================================================
module suma_serie_nbits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Co
`ifdef SUMA_SERIE_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;

    logic [N-1:0]  r_sa;
    logic [N-1:0]  r_sb;
    logic [N-1:0]  r_s;
    logic [N-1:0]  w_s_next;
    logic          r_carry;
    logic          r_co;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic          w_last;
    logic          w_cell_s;
    logic          w_cell_co;

    suma_1bit u_cell (
        .A  (r_sa[0]),
        .B  (r_sb[0]),
        .Ci (r_carry),
        .S  (w_cell_s),
        .Co (w_cell_co)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    // New sum bit enters at the MSB; after N shifts bit 0 lands in S[0].
    generate
        if (N == 1) begin : g_s_single
            assign w_s_next = w_cell_s;
        end else begin : g_s_shift
            assign w_s_next = {w_cell_s, r_s[N-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= (r_state == ST_RUN) && w_last;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa    <= A;
                        r_sb    <= B;
                        r_carry <= Ci;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_s     <= w_s_next;
                    r_carry <= w_cell_co;
                    r_cnt   <= r_cnt + CW'(1);
                    // Co is published only at the end so it stays in step with S.
                    if (w_last) begin
                        r_co <= w_cell_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUMA_SERIE_OVF_EN
    // On the last RUN edge the carry flip-flop holds the carry into the MSB.
    logic r_cmsb;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmsb <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_cmsb <= r_carry;
        end
    end
`endif

    // Outputs
    always_comb begin
        busy = (r_state == ST_RUN);
        done = r_done;
        S    = r_s;
        Co   = r_co;
`ifdef SUMA_SERIE_OVF_EN
        V    = r_cmsb ^ r_co;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_suma_serie_nbits.sv
`default_nettype none
// ============================================================================
//  Module      : tb_suma_serie_nbits
//  Description : Self-checking bench for suma_serie_nbits (N=8). Directed
//                scenarios plus randomized operands checked against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_suma_serie_nbits;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Ci;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Co;
`ifdef SUMA_SERIE_OVF_EN
    logic         V;
`endif

    int n_vec;
    int n_err;

    logic [N-1:0] exp_s;
    logic         exp_co;
    logic         exp_v;

    suma_serie_nbits #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co)
`ifdef SUMA_SERIE_OVF_EN
        ,
        .V     (V)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        logic [N:0] sum;
        int sa, sb, sv;
        sum    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        exp_s  = sum[N-1:0];
        exp_co = sum[N];
        sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
        sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
        sv = sa + sb + int'(ci);
        exp_v = (sv > (1 << (N-1)) - 1) || (sv < -(1 << (N-1)));
    endtask

    // Called just after an edge; start is captured at the next edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        start = 1'b1; A = a; B = b; Ci = ci;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Waits for done (bounded), optionally injecting a start at RUN cycle inj.
    task automatic finish_op(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic ci, input int inj);
        int lat;
        lat = 0;
        while (!done && lat < N + 4) begin
            if (lat == inj) begin
                start = 1'b1; A = '1; B = '1; Ci = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (!done && lat < N) chk("busy_in_run", 32'(busy), 32'd1);
        end
        model(a, b, ci);
        chk("latency", 32'(lat), 32'(N));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("S", 32'(S), 32'(exp_s));
        chk("Co", 32'(Co), 32'(exp_co));
`ifdef SUMA_SERIE_OVF_EN
        chk("V", 32'(V), 32'(exp_v));
`endif
    endtask

    // One idle cycle after done: pulse gone, result held.
    task automatic idle_check();
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("S_hold", 32'(S), 32'(exp_s));
        chk("Co_hold", 32'(Co), 32'(exp_co));
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_Co", 32'(Co), 32'd0);
`ifdef SUMA_SERIE_OVF_EN
        chk("rst_V", 32'(V), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic additions
        start_op(8'h5A, 8'h3C, 1'b0); finish_op(8'h5A, 8'h3C, 1'b0, -1); idle_check();
        chk("S_5A_3C", 32'(S), 32'h96);
        start_op(8'hFF, 8'h01, 1'b0); finish_op(8'hFF, 8'h01, 1'b0, -1); idle_check();
        start_op(8'h00, 8'h00, 1'b1); finish_op(8'h00, 8'h00, 1'b1, -1); idle_check();

        // start while busy is ignored
        start_op(8'h10, 8'h20, 1'b0); finish_op(8'h10, 8'h20, 1'b0, 2); idle_check();
        chk("S_ignored_start", 32'(S), 32'h30);

        // Reset mid-operation
        start_op(8'h11, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_S", 32'(S), 32'd0);
        chk("midrst_Co", 32'(Co), 32'd0);
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        start_op(8'hA5, 8'h5A, 1'b1); finish_op(8'hA5, 8'h5A, 1'b1, -1);

        // Back-to-back: start in the done cycle
        start = 1'b1; A = 8'h80; B = 8'h80; Ci = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_S_held", 32'(S), 32'h00);
        chk("b2b_Co_held", 32'(Co), 32'd1);
        finish_op(8'h80, 8'h80, 1'b0, -1); idle_check();

        // Overflow corner cases
        start_op(8'h7F, 8'h01, 1'b0); finish_op(8'h7F, 8'h01, 1'b0, -1);
        chk("S_7F_01", 32'(S), 32'h80);
`ifdef SUMA_SERIE_OVF_EN
        chk("V_7F_01", 32'(V), 32'd1);
`endif
        idle_check();
        start_op(8'hFF, 8'h01, 1'b0); finish_op(8'hFF, 8'h01, 1'b0, -1);
`ifdef SUMA_SERIE_OVF_EN
        chk("V_FF_01", 32'(V), 32'd0);
`endif
        idle_check();

        // Randomized operands, sometimes back-to-back
        for (int i = 0; i < 24; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            start_op(ra, rb, rc);
            finish_op(ra, rb, rc, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 2)) : -1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
